// File: rtl/imem_arb_pkg.sv
// ============================================================================
// Module : imem_arb_pkg
// Brief  : Shared types and constants for the instruction-memory arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_arb_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    FORCE  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IF   = 2'd1,
    SRC_LD   = 2'd2
  } rsp_src_t;

  localparam int WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/arb_fair_counter.sv
// ============================================================================
// Module : arb_fair_counter
// Brief  : Saturating count of fetch grants won while the loader waits.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_fair_counter #(
  parameter int FAIR_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic term
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (clr) begin
      r_cnt <= 4'd0;
    end else if (inc && (r_cnt != 4'hF)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Terminal count: the grant made at this value is the last one fetch gets.
  assign term = (r_cnt == 4'(FAIR_LIMIT - 1));

endmodule

`default_nettype wire

// File: rtl/imem_arbiter.sv
// ============================================================================
// Module : imem_arbiter
// Brief  : Fetch/loader arbiter for the single-port instruction memory.
//          Optional address checking enabled by IMEM_ARB_ADDR_CHECK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int FAIR_LIMIT  = 4,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req_valid,
  input  logic [31:0]   if_req_addr,
  output logic          if_req_ready,
  output logic          if_rsp_valid,
  output logic [31:0]   if_rsp_data,
  output logic          if_rsp_err,
  input  logic          ld_req_valid,
  input  logic          ld_req_we,
  input  logic [31:0]   ld_req_addr,
  input  logic [31:0]   ld_req_wdata,
  input  logic          ld_lock,
  output logic          ld_req_ready,
  output logic          ld_rsp_valid,
  output logic [31:0]   ld_rsp_data,
  output logic          ld_rsp_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  arb_state_t  r_state, w_state_nxt;
  rsp_src_t    r_src;
  logic        r_we, r_err, r_live;
  logic        w_en, w_gnt_if, w_gnt_ld, w_gnt, w_bad, w_term;
  logic [31:0] w_sel_addr;
  logic        w_unused_bits;

  // r_live keeps every output quiet for the first cycle after reset release.
  assign w_en = rst_n & r_live;

  always_comb begin
    w_gnt_if = 1'b0;
    w_gnt_ld = 1'b0;
    if (w_en) begin
      case (r_state)
        NORMAL: begin
          w_gnt_if = if_req_valid;
          w_gnt_ld = !if_req_valid && ld_req_valid;
        end
        FORCE: begin
          w_gnt_ld = ld_req_valid;
          w_gnt_if = !ld_req_valid && if_req_valid;
        end
        LOCKED:  w_gnt_ld = ld_req_valid;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (ld_lock) begin
      w_state_nxt = LOCKED;
    end else begin
      case (r_state)
        NORMAL:  if (w_gnt_if && ld_req_valid && w_term) w_state_nxt = FORCE;
        FORCE:   w_state_nxt = NORMAL;
        LOCKED:  w_state_nxt = NORMAL;
        default: w_state_nxt = NORMAL;
      endcase
    end
  end

  arb_fair_counter #(
    .FAIR_LIMIT (FAIR_LIMIT)
  ) u_fair_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_gnt_if & ld_req_valid),
    .clr   (w_gnt_ld | ~ld_req_valid),
    .term  (w_term)
  );

  assign w_gnt      = w_gnt_if | w_gnt_ld;
  assign w_sel_addr = w_gnt_ld ? ld_req_addr : if_req_addr;

`ifdef IMEM_ARB_ADDR_CHECK_EN
  assign w_bad = w_gnt && ((w_sel_addr[1:0] != 2'b00) ||
                           (w_sel_addr >= 32'(DEPTH_WORDS * WORD_BYTES)));
`else
  assign w_bad = 1'b0;
`endif

  // Upper/lower address bits are intentionally dropped when wrapping.
  assign w_unused_bits = ^{if_req_addr, ld_req_addr};

  assign if_req_ready = w_gnt_if;
  assign ld_req_ready = w_gnt_ld;
  assign mem_en       = w_gnt & ~w_bad;
  assign mem_we       = w_gnt_ld & ld_req_we & ~w_bad;
  assign mem_addr     = w_gnt ? w_sel_addr[AW+1:2] : '0;
  assign mem_wdata    = mem_we ? ld_req_wdata : 32'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= NORMAL;
      r_src   <= SRC_NONE;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_src   <= w_gnt_if ? SRC_IF : (w_gnt_ld ? SRC_LD : SRC_NONE);
      r_we    <= w_gnt_ld & ld_req_we;
      r_err   <= w_bad;
      r_live  <= 1'b1;
    end
  end

  // Gating with rst_n drops a response whose slot coincides with reset.
  assign if_rsp_valid = rst_n && (r_src == SRC_IF);
  assign ld_rsp_valid = rst_n && (r_src == SRC_LD);
  assign if_rsp_err   = if_rsp_valid & r_err;
  assign ld_rsp_err   = ld_rsp_valid & r_err;
  assign if_rsp_data  = (if_rsp_valid && !r_err) ? mem_rdata : 32'd0;
  assign ld_rsp_data  = (ld_rsp_valid && !r_err && !r_we) ? mem_rdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
// ============================================================================
// Module : tb_imem_arbiter
// Brief  : Directed, table-driven bench for imem_arbiter with a memory model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_arbiter;

  localparam int    AW = 6;
  localparam logic [31:0] BASE = 32'hA000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req_valid, ld_req_valid, ld_req_we, ld_lock;
  logic [31:0]   if_req_addr, ld_req_addr, ld_req_wdata;
  logic          if_req_ready, if_rsp_valid, if_rsp_err;
  logic          ld_req_ready, ld_rsp_valid, ld_rsp_err;
  logic [31:0]   if_rsp_data, ld_rsp_data, mem_wdata;
  logic [31:0]   mem_rdata = 32'd0;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  logic [31:0]   mem_model [64];
  logic          mem_inited = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.DEPTH_WORDS(64), .FAIR_LIMIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_valid (if_req_valid),
    .if_req_addr  (if_req_addr),
    .if_req_ready (if_req_ready),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .if_rsp_err   (if_rsp_err),
    .ld_req_valid (ld_req_valid),
    .ld_req_we    (ld_req_we),
    .ld_req_addr  (ld_req_addr),
    .ld_req_wdata (ld_req_wdata),
    .ld_lock      (ld_lock),
    .ld_req_ready (ld_req_ready),
    .ld_rsp_valid (ld_rsp_valid),
    .ld_rsp_data  (ld_rsp_data),
    .ld_rsp_err   (ld_rsp_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Synchronous one-cycle-read memory, preloaded with BASE + index.
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 64; i++) mem_model[i] <= BASE + 32'(i);
      mem_inited <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr];
    end
  end

  typedef struct {
    logic        ifv;  logic [31:0] ifa;
    logic        ldv;  logic ldwe; logic [31:0] lda; logic [31:0] ldd;
    logic        ifr;  logic ldr;  logic men; logic mwe; logic [5:0] madr;
    logic        ifrv; logic [31:0] ifrd;
    logic        ldrv; logic [31:0] ldrd;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic ifv, input logic [31:0] ifa,
    input logic ldv, input logic ldwe, input logic [31:0] lda, input logic [31:0] ldd,
    input logic ifr, input logic ldr, input logic men, input logic mwe, input logic [5:0] madr,
    input logic ifrv, input logic [31:0] ifrd, input logic ldrv, input logic [31:0] ldrd);
    vec_t v;
    v.ifv = ifv; v.ifa = ifa; v.ldv = ldv; v.ldwe = ldwe; v.lda = lda; v.ldd = ldd;
    v.ifr = ifr; v.ldr = ldr; v.men = men; v.mwe = mwe; v.madr = madr;
    v.ifrv = ifrv; v.ifrd = ifrd; v.ldrv = ldrv; v.ldrd = ldrd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ifv, input logic [31:0] ifa, input logic ldv,
                       input logic ldwe, input logic [31:0] lda, input logic [31:0] ldd);
    if_req_valid = ifv; if_req_addr = ifa;
    ld_req_valid = ldv; ld_req_we = ldwe; ld_req_addr = lda; ld_req_wdata = ldd;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " if_req_ready"}, 32'(if_req_ready), 32'd0);
    chk({tag, " ld_req_ready"}, 32'(ld_req_ready), 32'd0);
    chk({tag, " if_rsp_valid"}, 32'(if_rsp_valid), 32'd0);
    chk({tag, " ld_rsp_valid"}, 32'(ld_rsp_valid), 32'd0);
    chk({tag, " mem_en"},       32'(mem_en),       32'd0);
    chk({tag, " mem_addr"},     32'(mem_addr),     32'd0);
    chk({tag, " rsp_data"},     if_rsp_data | ld_rsp_data, 32'd0);
    chk({tag, " rsp_err"},      32'(if_rsp_err | ld_rsp_err), 32'd0);
  endtask

  initial begin
    //           ifv ifa    ldv we lda    ldd            ifr ldr men mwe madr ifrv ifrd      ldrv ldrd
    tbl[0]  = mk(1, 32'h0,  0, 0, 32'h0,  32'h0,         1, 0, 1, 0, 6'd0, 0, 32'h0,     0, 32'h0);
    tbl[1]  = mk(1, 32'h4,  0, 0, 32'h0,  32'h0,         1, 0, 1, 0, 6'd1, 1, BASE + 0,  0, 32'h0);
    tbl[2]  = mk(1, 32'h8,  0, 0, 32'h0,  32'h0,         1, 0, 1, 0, 6'd2, 1, BASE + 1,  0, 32'h0);
    tbl[3]  = mk(0, 32'h0,  1, 1, 32'h10, 32'hDEADBEEF,  0, 1, 1, 1, 6'd4, 1, BASE + 2,  0, 32'h0);
    tbl[4]  = mk(0, 32'h0,  1, 0, 32'h10, 32'h0,         0, 1, 1, 0, 6'd4, 0, 32'h0,     1, 32'h0);
    tbl[5]  = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,         0, 0, 0, 0, 6'd0, 0, 32'h0,     1, 32'hDEADBEEF);
    // Both requesters held valid: IF x4 then LD, twice.
    tbl[6]  = mk(1, 32'hC,  1, 0, 32'h14, 32'h0,         1, 0, 1, 0, 6'd3, 0, 32'h0,     0, 32'h0);
    tbl[7]  = mk(1, 32'hC,  1, 0, 32'h14, 32'h0,         1, 0, 1, 0, 6'd3, 1, BASE + 3,  0, 32'h0);
    tbl[8]  = mk(1, 32'hC,  1, 0, 32'h14, 32'h0,         1, 0, 1, 0, 6'd3, 1, BASE + 3,  0, 32'h0);
    tbl[9]  = mk(1, 32'hC,  1, 0, 32'h14, 32'h0,         1, 0, 1, 0, 6'd3, 1, BASE + 3,  0, 32'h0);
    tbl[10] = mk(1, 32'hC,  1, 0, 32'h14, 32'h0,         0, 1, 1, 0, 6'd5, 1, BASE + 3,  0, 32'h0);
    tbl[11] = mk(1, 32'hC,  1, 0, 32'h14, 32'h0,         1, 0, 1, 0, 6'd3, 0, 32'h0,     1, BASE + 5);
    tbl[12] = mk(1, 32'hC,  1, 0, 32'h14, 32'h0,         1, 0, 1, 0, 6'd3, 1, BASE + 3,  0, 32'h0);
    tbl[13] = mk(1, 32'hC,  1, 0, 32'h14, 32'h0,         1, 0, 1, 0, 6'd3, 1, BASE + 3,  0, 32'h0);
    tbl[14] = mk(1, 32'hC,  1, 0, 32'h14, 32'h0,         1, 0, 1, 0, 6'd3, 1, BASE + 3,  0, 32'h0);
    tbl[15] = mk(1, 32'hC,  1, 0, 32'h14, 32'h0,         0, 1, 1, 0, 6'd5, 1, BASE + 3,  0, 32'h0);
    tbl[16] = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,         0, 0, 0, 0, 6'd0, 0, 32'h0,     1, BASE + 5);

    rst_n = 1'b0; ld_lock = 1'b0;
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    tick(); tick();
    @(negedge clk);
    chk_quiet("reset");

    // First cycle after release: a pending fetch is still not granted.
    tick();
    rst_n = 1'b1;
    drive(1, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk_quiet("release");
    tick();

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].ifv, tbl[i].ifa, tbl[i].ldv, tbl[i].ldwe, tbl[i].lda, tbl[i].ldd);
      @(negedge clk);
      chk($sformatf("v%0d if_req_ready", i), 32'(if_req_ready), 32'(tbl[i].ifr));
      chk($sformatf("v%0d ld_req_ready", i), 32'(ld_req_ready), 32'(tbl[i].ldr));
      chk($sformatf("v%0d mem_en", i),       32'(mem_en),       32'(tbl[i].men));
      chk($sformatf("v%0d mem_we", i),       32'(mem_we),       32'(tbl[i].mwe));
      chk($sformatf("v%0d mem_addr", i),     32'(mem_addr),     32'(tbl[i].madr));
      chk($sformatf("v%0d if_rsp_valid", i), 32'(if_rsp_valid), 32'(tbl[i].ifrv));
      chk($sformatf("v%0d ld_rsp_valid", i), 32'(ld_rsp_valid), 32'(tbl[i].ldrv));
      if (tbl[i].ifrv) chk($sformatf("v%0d if_rsp_data", i), if_rsp_data, tbl[i].ifrd);
      if (tbl[i].ldrv) chk($sformatf("v%0d ld_rsp_data", i), ld_rsp_data, tbl[i].ldrd);
      tick();
    end

    // Lock: fetch is shut out, loader still served, fetch returns a cycle after release.
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    ld_lock = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h8, (i == 1), 0, 32'h14, 32'h0);
      @(negedge clk);
      chk($sformatf("lock%0d if_req_ready", i), 32'(if_req_ready), 32'd0);
      if (i == 1) chk("lock ld_req_ready", 32'(ld_req_ready), 32'd1);
      if (i == 2) chk("lock ld_rsp_data", ld_rsp_data, BASE + 5);
      tick();
    end
    ld_lock = 1'b0;
    @(negedge clk);
    chk("unlock same-cycle if_req_ready", 32'(if_req_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("unlock next if_req_ready", 32'(if_req_ready), 32'd1);
    chk("unlock mem_addr", 32'(mem_addr), 32'd2);
    tick();
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("unlock if_rsp_data", if_rsp_data, BASE + 2);
    tick();

    // Reset in the response cycle drops the response; fetch wins first after reset.
    drive(1, 32'h0, 1, 0, 32'h14, 32'h0);
    @(negedge clk);
    chk("pre-reset if_req_ready", 32'(if_req_ready), 32'd1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk_quiet("midreset");
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("rerelease");
    tick();
    @(negedge clk);
    chk("post-reset if_req_ready", 32'(if_req_ready), 32'd1);
    chk("post-reset ld_req_ready", 32'(ld_req_ready), 32'd0);
    tick();
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("post-reset if_rsp_data", if_rsp_data, BASE + 0);
    tick();

`ifdef IMEM_ARB_ADDR_CHECK_EN
    drive(1, 32'h2, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("misaligned if_req_ready", 32'(if_req_ready), 32'd1);
    chk("misaligned mem_en", 32'(mem_en), 32'd0);
    tick();
    drive(0, 32'h0, 1, 1, 32'h100, 32'h55);
    @(negedge clk);
    chk("misaligned if_rsp_err", 32'(if_rsp_err), 32'd1);
    chk("misaligned if_rsp_data", if_rsp_data, 32'd0);
    chk("oob ld_req_ready", 32'(ld_req_ready), 32'd1);
    chk("oob mem_en", 32'(mem_en), 32'd0);
    tick();
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("oob ld_rsp_valid", 32'(ld_rsp_valid), 32'd1);
    chk("oob ld_rsp_err", 32'(ld_rsp_err), 32'd1);
    chk("oob mem[0] unchanged", mem_model[0], BASE + 0);
    tick();
`else
    drive(0, 32'h0, 1, 1, 32'h100, 32'h12345678);
    @(negedge clk);
    chk("alias mem_we", 32'(mem_we), 32'd1);
    chk("alias mem_addr", 32'(mem_addr), 32'd0);
    tick();
    drive(1, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("alias ld_rsp_valid", 32'(ld_rsp_valid), 32'd1);
    chk("alias ld_rsp_err", 32'(ld_rsp_err), 32'd0);
    tick();
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("alias if_rsp_data", if_rsp_data, 32'h12345678);
    chk("alias if_rsp_err", 32'(if_rsp_err), 32'd0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
